// File: rtl/trigger_conditioner_if.sv
// Signal bundle between the trigger conditioner and its surroundings.
// When TRIGGER_BUSY_VETO_EN is defined, the bundle also carries readout_busy.
interface trigger_conditioner_if;
    logic        trig_in;
    logic        trig_polarity;
    logic        trig_enable;
    logic [3:0]  min_width;
    logic [15:0] dead_time;
    logic        ts_reset_cmd;
`ifdef TRIGGER_BUSY_VETO_EN
    logic        readout_busy;
`endif
    logic        data_trigger;
    logic        ts_reset;
    logic        trigger_busy;
    logic [31:0] trigger_count;
    logic [15:0] lost_count;

    modport master (
`ifdef TRIGGER_BUSY_VETO_EN
        output readout_busy,
`endif
        output trig_in, trig_polarity, trig_enable, min_width, dead_time, ts_reset_cmd,
        input  data_trigger, ts_reset, trigger_busy, trigger_count, lost_count
    );

    modport slave (
`ifdef TRIGGER_BUSY_VETO_EN
        input  readout_busy,
`endif
        input  trig_in, trig_polarity, trig_enable, min_width, dead_time, ts_reset_cmd,
        output data_trigger, ts_reset, trigger_busy, trigger_count, lost_count
    );
endinterface

// File: rtl/trigger_conditioner.sv
// External trigger conditioner. The external trigger is synchronised,
// polarity-adjusted and glitch-filtered, then turned into a stretched
// DataTrigger pulse followed by dead-time. The time-stamp-reset command
// produces a one-cycle TimeStampReset pulse and blanks triggers around it.
// Optional macro TRIGGER_BUSY_VETO_EN adds a readout_busy veto in IDLE.
//
// state   | meaning
// IDLE    | waiting for an enabled edge
// FILTER  | edge seen, counting consecutive high samples
// FIRE    | data_trigger high for PULSE_WIDTH cycles
// DEAD    | dead-time after the pulse, edges counted as lost
// TSBLANK | blanking after a time-stamp reset, edges counted as lost
module trigger_conditioner #(
    parameter int PULSE_WIDTH = 4,
    parameter int TS_BLANK    = 48,
    parameter int SYNC_STAGES = 2
) (
    input logic               clk,
    input logic               reset,
    trigger_conditioner_if.slave bus
);

    typedef enum logic [2:0] {IDLE, FILTER, FIRE, DEAD, TSBLANK} state_t;

    localparam logic [3:0]  PULSE_LOAD = 4'(PULSE_WIDTH - 1);
    localparam logic [15:0] BLANK_LOAD = 16'(TS_BLANK - 1);

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   s, s_d, rise;
    logic [3:0]             filt_cnt, filt_cnt_nxt;
    logic [3:0]             pulse_cnt, pulse_cnt_nxt;
    logic [15:0]            dead_cnt, dead_cnt_nxt;
    logic [15:0]            blank_cnt, blank_cnt_nxt;
    logic                   lost_inc;
    logic                   fire_entry;
    logic                   data_trigger_r, ts_reset_r;
    logic [31:0]            trigger_count_r;
    logic [15:0]            lost_count_r;

    // Polarity is applied after the synchroniser so flipping it never
    // creates metastability, only (at most) one spurious edge.
    assign s    = sync_ff[SYNC_STAGES-1] ^ bus.trig_polarity;
    assign rise = s & ~s_d;

    // Next-state and counter loads; the time-stamp command overrides everything.
    always_comb begin
        state_nxt     = state;
        filt_cnt_nxt  = filt_cnt;
        pulse_cnt_nxt = pulse_cnt;
        dead_cnt_nxt  = dead_cnt;
        blank_cnt_nxt = blank_cnt;
        lost_inc      = 1'b0;
        if (bus.ts_reset_cmd) begin
            state_nxt     = TSBLANK;
            blank_cnt_nxt = BLANK_LOAD;
            lost_inc      = rise;
        end else begin
            case (state)
                IDLE: begin
                    if (rise && bus.trig_enable) begin
`ifdef TRIGGER_BUSY_VETO_EN
                        if (bus.readout_busy) begin
                            lost_inc = 1'b1;
                        end else
`endif
                        if (bus.min_width == 4'd0) begin
                            state_nxt     = FIRE;
                            pulse_cnt_nxt = PULSE_LOAD;
                        end else begin
                            state_nxt    = FILTER;
                            filt_cnt_nxt = 4'd1;
                        end
                    end
                end
                FILTER: begin
                    lost_inc = rise;
                    if (!s || !bus.trig_enable) begin
                        state_nxt = IDLE;
                    end else if (filt_cnt >= bus.min_width) begin
                        state_nxt     = FIRE;
                        pulse_cnt_nxt = PULSE_LOAD;
                    end else begin
                        filt_cnt_nxt = filt_cnt + 4'd1;
                    end
                end
                FIRE: begin
                    lost_inc = rise;
                    if (pulse_cnt == 4'd0) begin
                        if (bus.dead_time == 16'd0) begin
                            state_nxt = IDLE;
                        end else begin
                            state_nxt    = DEAD;
                            dead_cnt_nxt = bus.dead_time - 16'd1;
                        end
                    end else begin
                        pulse_cnt_nxt = pulse_cnt - 4'd1;
                    end
                end
                DEAD: begin
                    lost_inc = rise;
                    if (dead_cnt == 16'd0) state_nxt = IDLE;
                    else dead_cnt_nxt = dead_cnt - 16'd1;
                end
                TSBLANK: begin
                    lost_inc = rise;
                    if (blank_cnt == 16'd0) state_nxt = IDLE;
                    else blank_cnt_nxt = blank_cnt - 16'd1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign fire_entry = (state_nxt == FIRE) && (state != FIRE);

    // State, synchroniser, timers, registered outputs and status counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            sync_ff         <= '0;
            s_d             <= 1'b0;
            filt_cnt        <= 4'd0;
            pulse_cnt       <= 4'd0;
            dead_cnt        <= 16'd0;
            blank_cnt       <= 16'd0;
            data_trigger_r  <= 1'b0;
            ts_reset_r      <= 1'b0;
            trigger_count_r <= 32'd0;
            lost_count_r    <= 16'd0;
        end else begin
            state          <= state_nxt;
            sync_ff        <= {sync_ff[SYNC_STAGES-2:0], bus.trig_in};
            s_d            <= s;
            filt_cnt       <= filt_cnt_nxt;
            pulse_cnt      <= pulse_cnt_nxt;
            dead_cnt       <= dead_cnt_nxt;
            blank_cnt      <= blank_cnt_nxt;
            data_trigger_r <= (state_nxt == FIRE);
            ts_reset_r     <= bus.ts_reset_cmd;
            if (bus.ts_reset_cmd) begin
                trigger_count_r <= 32'd0;
                lost_count_r    <= {15'd0, lost_inc};
            end else begin
                if (fire_entry) trigger_count_r <= trigger_count_r + 32'd1;
                if (lost_inc && (lost_count_r != 16'hFFFF)) lost_count_r <= lost_count_r + 16'd1;
            end
        end
    end

    assign bus.data_trigger  = data_trigger_r;
    assign bus.ts_reset      = ts_reset_r;
    assign bus.trigger_busy  = (state != IDLE);
    assign bus.trigger_count = trigger_count_r;
    assign bus.lost_count    = lost_count_r;

endmodule

// File: tb/tb_trigger_conditioner.sv
// Directed bench for trigger_conditioner (PULSE_WIDTH=4, TS_BLANK=48, SYNC_STAGES=2).
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
// Tick k of a loop is the k-th rising edge after the first stimulus was applied.
module tb_trigger_conditioner;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    trigger_conditioner_if bus();

    trigger_conditioner #(.PULSE_WIDTH(4), .TS_BLANK(48), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.trig_in       = 1'b0;
        bus.trig_polarity = 1'b0;
        bus.trig_enable   = 1'b1;
        bus.min_width     = 4'd0;
        bus.dead_time     = 16'd0;
        bus.ts_reset_cmd  = 1'b0;
`ifdef TRIGGER_BUSY_VETO_EN
        bus.readout_busy  = 1'b0;
`endif
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.data_trigger !== 1'b0) begin failures++; $display("FAIL reset_dt got=%0b exp=0", bus.data_trigger); end
        checks++; if (bus.ts_reset !== 1'b0) begin failures++; $display("FAIL reset_ts got=%0b exp=0", bus.ts_reset); end
        checks++; if (bus.trigger_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.trigger_busy); end
        checks++; if (bus.trigger_count !== 32'd0) begin failures++; $display("FAIL reset_tcnt got=%0d exp=0", bus.trigger_count); end
        checks++; if (bus.lost_count !== 16'd0) begin failures++; $display("FAIL reset_lcnt got=%0d exp=0", bus.lost_count); end
    endtask

    // MinWidth=0, DeadTime=0: pulse on ticks 3..6.
    task automatic test_basic();
        logic exp;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            bus.trig_in = (c < 10);
            tick();
            exp = (c + 1 >= 3) && (c + 1 <= 6);
            checks++; if (bus.data_trigger !== exp) begin failures++; $display("FAIL basic_dt tick=%0d got=%0b exp=%0b", c + 1, bus.data_trigger, exp); end
        end
        checks++; if (bus.trigger_count !== 32'd1) begin failures++; $display("FAIL basic_tcnt got=%0d exp=1", bus.trigger_count); end
        checks++; if (bus.lost_count !== 16'd0) begin failures++; $display("FAIL basic_lcnt got=%0d exp=0", bus.lost_count); end
    endtask

    // MinWidth=3: 2-cycle glitch rejected, 6-cycle pulse sampled at tick 11 fires on ticks 16..19.
    task automatic test_filter();
        logic exp;
        do_reset();
        bus.min_width = 4'd3;
        for (int c = 0; c < 30; c++) begin
            bus.trig_in = (c < 2) || (c >= 10 && c < 16);
            tick();
            exp = (c + 1 >= 16) && (c + 1 <= 19);
            checks++; if (bus.data_trigger !== exp) begin failures++; $display("FAIL filter_dt tick=%0d got=%0b exp=%0b", c + 1, bus.data_trigger, exp); end
        end
        checks++; if (bus.trigger_count !== 32'd1) begin failures++; $display("FAIL filter_tcnt got=%0d exp=1", bus.trigger_count); end
        checks++; if (bus.lost_count !== 16'd0) begin failures++; $display("FAIL filter_lcnt got=%0d exp=0", bus.lost_count); end
    endtask

    // DeadTime=100: pulse ends tick 7, DEAD until tick 107; four pulses lost, the one at 150 fires.
    task automatic test_dead_time();
        do_reset();
        bus.dead_time = 16'd100;
        for (int c = 0; c < 170; c++) begin
            bus.trig_in = ((c < 100) && (c % 20 < 5)) || (c >= 150 && c < 155);
            tick();
            if (c + 1 == 106) begin
                checks++; if (bus.trigger_busy !== 1'b1) begin failures++; $display("FAIL dead_busy106 got=%0b exp=1", bus.trigger_busy); end
            end
            if (c + 1 == 107) begin
                checks++; if (bus.trigger_busy !== 1'b0) begin failures++; $display("FAIL dead_busy107 got=%0b exp=0", bus.trigger_busy); end
            end
            if (c + 1 == 140) begin
                checks++; if (bus.trigger_count !== 32'd1) begin failures++; $display("FAIL dead_tcnt140 got=%0d exp=1", bus.trigger_count); end
                checks++; if (bus.lost_count !== 16'd4) begin failures++; $display("FAIL dead_lcnt140 got=%0d exp=4", bus.lost_count); end
            end
            if (c + 1 == 152) begin
                checks++; if (bus.data_trigger !== 1'b0) begin failures++; $display("FAIL dead_dt152 got=%0b exp=0", bus.data_trigger); end
            end
            if (c + 1 == 153) begin
                checks++; if (bus.data_trigger !== 1'b1) begin failures++; $display("FAIL dead_dt153 got=%0b exp=1", bus.data_trigger); end
            end
        end
        checks++; if (bus.trigger_count !== 32'd2) begin failures++; $display("FAIL dead_tcnt got=%0d exp=2", bus.trigger_count); end
        checks++; if (bus.lost_count !== 16'd4) begin failures++; $display("FAIL dead_lcnt got=%0d exp=4", bus.lost_count); end
    endtask

    // Command captured at tick 5 (second pulse cycle); blanking covers ticks 5..52.
    task automatic test_cmd_during_fire();
        do_reset();
        for (int c = 0; c < 80; c++) begin
            bus.trig_in      = (c < 5) || (c >= 34 && c < 37) || (c >= 64 && c < 67);
            bus.ts_reset_cmd = (c == 4);
            tick();
            if (c + 1 == 4) begin
                checks++; if (bus.data_trigger !== 1'b1) begin failures++; $display("FAIL cmd_dt4 got=%0b exp=1", bus.data_trigger); end
                checks++; if (bus.trigger_count !== 32'd1) begin failures++; $display("FAIL cmd_tcnt4 got=%0d exp=1", bus.trigger_count); end
            end
            if (c + 1 == 5) begin
                checks++; if (bus.data_trigger !== 1'b0) begin failures++; $display("FAIL cmd_dt5 got=%0b exp=0", bus.data_trigger); end
                checks++; if (bus.ts_reset !== 1'b1) begin failures++; $display("FAIL cmd_ts5 got=%0b exp=1", bus.ts_reset); end
                checks++; if (bus.trigger_count !== 32'd0) begin failures++; $display("FAIL cmd_tcnt5 got=%0d exp=0", bus.trigger_count); end
            end
            if (c + 1 == 6) begin
                checks++; if (bus.ts_reset !== 1'b0) begin failures++; $display("FAIL cmd_ts6 got=%0b exp=0", bus.ts_reset); end
            end
            if (c + 1 == 40) begin
                checks++; if (bus.data_trigger !== 1'b0) begin failures++; $display("FAIL cmd_dt40 got=%0b exp=0", bus.data_trigger); end
                checks++; if (bus.lost_count !== 16'd1) begin failures++; $display("FAIL cmd_lcnt40 got=%0d exp=1", bus.lost_count); end
            end
            if (c + 1 == 67) begin
                checks++; if (bus.data_trigger !== 1'b1) begin failures++; $display("FAIL cmd_dt67 got=%0b exp=1", bus.data_trigger); end
            end
        end
        checks++; if (bus.trigger_count !== 32'd1) begin failures++; $display("FAIL cmd_tcnt got=%0d exp=1", bus.trigger_count); end
        checks++; if (bus.lost_count !== 16'd1) begin failures++; $display("FAIL cmd_lcnt got=%0d exp=1", bus.lost_count); end
    endtask

    // Edge and command land on the same edge (tick 3): command wins, edge is lost.
    task automatic test_cmd_collision();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            bus.trig_in      = (c < 4);
            bus.ts_reset_cmd = (c == 2);
            tick();
            if (c + 1 == 3) begin
                checks++; if (bus.lost_count !== 16'd1) begin failures++; $display("FAIL coll_lcnt got=%0d exp=1", bus.lost_count); end
                checks++; if (bus.trigger_count !== 32'd0) begin failures++; $display("FAIL coll_tcnt got=%0d exp=0", bus.trigger_count); end
                checks++; if (bus.ts_reset !== 1'b1) begin failures++; $display("FAIL coll_ts got=%0b exp=1", bus.ts_reset); end
            end
            checks++; if (bus.data_trigger !== 1'b0) begin failures++; $display("FAIL coll_dt tick=%0d got=%0b exp=0", c + 1, bus.data_trigger); end
        end
    endtask

    // Falling-edge trigger with TrigPolarity=1, then three edges with TrigEnable=0.
    task automatic test_polarity_enable();
        do_reset();
        bus.trig_enable = 1'b0;
        bus.trig_in     = 1'b1;
        repeat (4) tick();
        bus.trig_polarity = 1'b1;
        repeat (4) tick();
        bus.trig_enable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus.trig_in = 1'b0;
            tick();
            if (c + 1 == 2) begin
                checks++; if (bus.data_trigger !== 1'b0) begin failures++; $display("FAIL pol_dt2 got=%0b exp=0", bus.data_trigger); end
            end
            if (c + 1 == 3) begin
                checks++; if (bus.data_trigger !== 1'b1) begin failures++; $display("FAIL pol_dt3 got=%0b exp=1", bus.data_trigger); end
            end
        end
        checks++; if (bus.trigger_count !== 32'd1) begin failures++; $display("FAIL pol_tcnt got=%0d exp=1", bus.trigger_count); end
        bus.trig_enable = 1'b0;
        for (int c = 0; c < 20; c++) begin
            bus.trig_in = (c % 6 < 3);
            tick();
            checks++; if (bus.data_trigger !== 1'b0) begin failures++; $display("FAIL en_dt tick=%0d got=%0b exp=0", c + 1, bus.data_trigger); end
        end
        checks++; if (bus.lost_count !== 16'd0) begin failures++; $display("FAIL en_lcnt got=%0d exp=0", bus.lost_count); end
        checks++; if (bus.trigger_count !== 32'd1) begin failures++; $display("FAIL en_tcnt got=%0d exp=1", bus.trigger_count); end
    endtask

    // TriggerCount wraps from 2^32-1; LostCount saturates at 0xFFFF during dead-time.
    task automatic test_wrap_saturate();
        do_reset();
        bus.dead_time = 16'd200;
        force dut.trigger_count_r = 32'hFFFF_FFFF;
        tick();
        release dut.trigger_count_r;
        for (int c = 0; c < 10; c++) begin
            bus.trig_in = (c < 5);
            tick();
        end
        checks++; if (bus.trigger_count !== 32'd0) begin failures++; $display("FAIL wrap_tcnt got=%0h exp=0", bus.trigger_count); end
        force dut.lost_count_r = 16'hFFFD;
        tick();
        release dut.lost_count_r;
        for (int c = 0; c < 40; c++) begin
            bus.trig_in = (c < 20) && (c % 4 < 2);
            tick();
            if (c + 1 == 4) begin
                checks++; if (bus.lost_count !== 16'hFFFE) begin failures++; $display("FAIL sat_lcnt4 got=%0h exp=fffe", bus.lost_count); end
            end
        end
        checks++; if (bus.lost_count !== 16'hFFFF) begin failures++; $display("FAIL sat_lcnt got=%0h exp=ffff", bus.lost_count); end
        checks++; if (bus.trigger_busy !== 1'b1) begin failures++; $display("FAIL sat_busy got=%0b exp=1", bus.trigger_busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_filter();
        test_dead_time();
        test_cmd_during_fire();
        test_cmd_collision();
        test_polarity_enable();
        test_wrap_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
